// File: rtl/param_updown_counter.sv
// Parametrised up/down modulo-N counter with load, enable and
// wrap-or-saturate boundary handling; wrap pulse and boundary flags.
module param_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = (1 << WIDTH) - 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             c,
    input  logic             r,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] o,
    output logic             wrap,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;
    logic             inc_wrap;
    logic             dec_wrap;

    assign at_max = (cnt_q == MAXV);
    assign at_min = (cnt_q == '0);

    // Out-of-range load values clamp so the count never leaves 0..MAX_VAL.
    assign ld_val = (d > MAXV) ? MAXV : d;

    always_comb begin
        inc_val  = cnt_q + ONE;
        inc_wrap = 1'b0;
        if (at_max) begin
            if (SATURATE) begin
                inc_val = cnt_q;
            end else begin
                inc_val  = '0;
                inc_wrap = 1'b1;
            end
        end
    end

    always_comb begin
        dec_val  = cnt_q - ONE;
        dec_wrap = 1'b0;
        if (at_min) begin
            if (SATURATE) begin
                dec_val = cnt_q;
            end else begin
                dec_val  = MAXV;
                dec_wrap = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (ld) begin
            cnt_d = ld_val;
        end else if (en) begin
            if (up) begin
                cnt_d  = inc_val;
                wrap_d = inc_wrap;
            end else begin
                cnt_d  = dec_val;
                wrap_d = dec_wrap;
            end
        end
    end

    always_ff @(posedge c) begin
        if (!r) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign o    = cnt_q;
    assign wrap = wrap_q;

endmodule
